// File: rtl/i2c_mem_loader_pkg.sv
// Shared definitions for the I2C instruction-memory loader.
// Holds the FSM state encodings, the R/W bit polarity and the rule used to
// size the byte-within-word counter.
package i2c_mem_loader_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_PTR       = 4'd3;
  localparam logic [3:0] ST_PTR_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RD_ACK    = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  localparam logic I2C_RW_READ = 1'b1;

  // A one-byte word still needs a one-bit counter to keep the logic legal.
  function automatic int byte_cnt_w(input int word_bytes);
    return (word_bytes > 1) ? $clog2(word_bytes) : 1;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Oversampling front end for the I2C pins.
// Ports: i_clk/i_rst system clock and sync reset; i_scl/i_sda raw bus pins;
// scl_rise/scl_fall one-cycle SCL edge pulses; sda_s synchronized SDA;
// start/stop one-cycle bus condition pulses.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start,
  output logic stop
);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      // p0/p1: two-flop synchronizer; p2: history for edge detection
      scl_p0 <= i_scl;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= i_sda;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise = scl_p1 & ~scl_p2;
  assign scl_fall = ~scl_p1 & scl_p2;
  assign sda_s    = sda_p1;
  assign start    = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop     = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

endmodule

// File: rtl/i2c_mem_loader.sv
// I2C slave programming port for the processor instruction memory.
// Ports: i_clk/i_rst system clock and sync active-high reset; i_scl/i_sda
// bus pins; o_sda_oe open-drain pull-down enable; o_mem_addr word pointer;
// o_mem_wdata assembled word; o_mem_we/o_mem_re one-cycle strobes;
// i_mem_rdata read data valid the cycle after o_mem_re; o_busy addressed
// transfer in progress.
module i2c_mem_loader
  import i2c_mem_loader_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h2A,
  parameter int         ADDR_W     = 8,
  parameter int         DEPTH      = 2**ADDR_W,
  parameter int         WORD_BYTES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_scl,
  input  logic                    i_sda,
  output logic                    o_sda_oe,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [8*WORD_BYTES-1:0] o_mem_wdata,
  output logic                    o_mem_we,
  output logic                    o_mem_re,
  input  logic [8*WORD_BYTES-1:0] i_mem_rdata,
  output logic                    o_busy
);

  localparam int                KW       = byte_cnt_w(WORD_BYTES);
  localparam int                WORD_W   = 8 * WORD_BYTES;
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [KW-1:0]     K_LAST   = KW'(WORD_BYTES - 1);

  logic scl_rise, scl_fall, sda_s, start, stop;

  i2c_line_sync u_line_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_scl    (i_scl),
    .i_sda    (i_sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start    (start),
    .stop     (stop)
  );

  logic [3:0]        state;
  logic [3:0]        bit_cnt;
  logic [KW-1:0]     k;
  logic [ADDR_W-1:0] ptr;
  logic              ack_phase;
  logic              rw;
  logic              mack;
  logic              re_p1;
  logic [7:0]        rx_sh;
  logic [7:0]        tx_sh;
  logic [WORD_W-1:0] wbuf;
  logic [WORD_W-1:0] rword;
  logic [7:0]        rx_byte;
  logic [7:0]        rd_byte;
  logic [WORD_W-1:0] wbuf_nxt;

  // Explicit compare keeps the wrap correct for non-power-of-two DEPTH.
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + ADDR_W'(1);
  endfunction

  function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] w,
                                                   input logic [KW-1:0]     idx,
                                                   input logic [7:0]        b);
    logic [WORD_W-1:0] r;
    r = w;
    for (int i = 0; i < WORD_BYTES; i++)
      if (int'(idx) == i) r[8*i +: 8] = b;
    return r;
  endfunction

  always_comb begin
    rd_byte = rword[7:0];
    for (int i = 0; i < WORD_BYTES; i++)
      if (int'(k) == i) rd_byte = rword[8*i +: 8];
  end

  assign rx_byte    = {rx_sh[6:0], sda_s};
  assign wbuf_nxt   = place_byte(wbuf, k, rx_byte);
  assign o_mem_addr = ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      k           <= '0;
      ptr         <= '0;
      ack_phase   <= 1'b0;
      rw          <= 1'b0;
      mack        <= 1'b0;
      re_p1       <= 1'b0;
      o_sda_oe    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_mem_wdata <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_mem_we <= 1'b0;
      o_mem_re <= 1'b0;
      // p1: memory answers one cycle after the read request
      re_p1 <= o_mem_re;
      if (re_p1) rword <= i_mem_rdata;
      if (o_mem_we) ptr <= ptr_next(ptr);

      if (stop) begin
        state    <= ST_IDLE;
        o_sda_oe <= 1'b0;
        k        <= '0;
        bit_cnt  <= '0;
        o_busy   <= 1'b0;
      end else if (start) begin
        state    <= ST_ADDR;
        o_sda_oe <= 1'b0;
        k        <= '0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              rx_sh   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                if (state == ST_ADDR) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state  <= ST_ADDR_ACK;
                    rw     <= rx_byte[0];
                    o_busy <= 1'b1;
                    if (rx_byte[0] == I2C_RW_READ) o_mem_re <= 1'b1;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else if (state == ST_PTR) begin
                  if (int'(rx_byte) < DEPTH) begin
                    ptr   <= rx_byte[ADDR_W-1:0];
                    state <= ST_PTR_ACK;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else begin
                  wbuf  <= wbuf_nxt;
                  state <= ST_WDATA_ACK;
                  if (k == K_LAST) begin
                    o_mem_we    <= 1'b1;
                    o_mem_wdata <= wbuf_nxt;
                    k           <= '0;
                  end else begin
                    k <= k + KW'(1);
                  end
                end
              end
            end
          end
          // First SCL fall after the byte pulls SDA low, the next one releases it.
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                o_sda_oe  <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                o_sda_oe  <= 1'b0;
                ack_phase <= 1'b0;
                bit_cnt   <= '0;
                if (state == ST_ADDR_ACK && rw == I2C_RW_READ) begin
                  o_sda_oe <= ~rd_byte[7];
                  tx_sh    <= {rd_byte[6:0], 1'b0};
                  state    <= ST_RDATA;
                end else if (state == ST_ADDR_ACK) begin
                  state <= ST_PTR;
                end else begin
                  state <= ST_WDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                o_sda_oe <= 1'b0;
                bit_cnt  <= '0;
                mack     <= 1'b0;
                state    <= ST_RD_ACK;
              end else begin
                o_sda_oe <= ~tx_sh[7];
                tx_sh    <= {tx_sh[6:0], 1'b0};
              end
            end
          end
          // Pointer only advances once the master has ACKed the last byte.
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s) begin
                state <= ST_IGNORE;
              end else begin
                mack <= 1'b1;
                if (k == K_LAST) begin
                  k        <= '0;
                  ptr      <= ptr_next(ptr);
                  o_mem_re <= 1'b1;
                end else begin
                  k <= k + KW'(1);
                end
              end
            end
            if (scl_fall && mack) begin
              mack     <= 1'b0;
              o_sda_oe <= ~rd_byte[7];
              tx_sh    <= {rd_byte[6:0], 1'b0};
              state    <= ST_RDATA;
            end
          end
          default: o_sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_loader.sv
module tb_i2c_mem_loader;

  localparam int Q = 5;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  logic        oe_a, we_a, re_a, busy_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        oe_b, we_b, re_b, busy_b;
  logic [3:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;
  wire         sda_line = sda_m & ~oe_a & ~oe_b;

  int checks = 0;
  int errors = 0;
  ev_t exp_a[$];
  ev_t exp_b[$];
  logic [7:0] exp_rd[$];

  i2c_mem_loader dut_a (
    .i_clk(clk), .i_rst(rst), .i_scl(scl_m), .i_sda(sda_line),
    .o_sda_oe(oe_a), .o_mem_addr(addr_a), .o_mem_wdata(wdata_a),
    .o_mem_we(we_a), .o_mem_re(re_a), .i_mem_rdata(rdata_a), .o_busy(busy_a)
  );

  i2c_mem_loader #(.DEV_ADDR(7'h3C), .ADDR_W(4), .DEPTH(12), .WORD_BYTES(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_scl(scl_m), .i_sda(sda_line),
    .o_sda_oe(oe_b), .o_mem_addr(addr_b), .o_mem_wdata(wdata_b),
    .o_mem_we(we_b), .o_mem_re(re_b), .i_mem_rdata(rdata_b), .o_busy(busy_b)
  );

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [16];
  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wdata_a;
    if (re_a) rdata_a <= mem_a[addr_a];
    if (we_b) mem_b[addr_b] <= wdata_b;
    if (re_b) rdata_b <= mem_b[addr_b];
  end

  function automatic ev_t mk_ev(input logic wr, input logic [7:0] a, input logic [31:0] d);
    ev_t e;
    e.wr = wr; e.addr = a; e.data = d;
    return e;
  endfunction

  // Scoreboard: every strobe pops one expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst === 1'b0) begin
      if (we_a || re_a) begin
        checks++;
        if (we_a && re_a) begin
          errors++; $display("FAIL a_strobe_overlap: we=%b re=%b, required not both", we_a, re_a);
        end else if (exp_a.size() == 0) begin
          errors++; $display("FAIL a_unexpected_strobe: we=%b re=%b addr=%h, required none", we_a, re_a, addr_a);
        end else begin
          e = exp_a.pop_front();
          if (e.wr !== we_a || e.addr !== addr_a || (e.wr && e.data !== wdata_a)) begin
            errors++;
            $display("FAIL a_strobe: we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                     we_a, addr_a, wdata_a, e.wr, e.addr, e.data);
          end
        end
      end
      if (we_b || re_b) begin
        checks++;
        if (we_b && re_b) begin
          errors++; $display("FAIL b_strobe_overlap: we=%b re=%b, required not both", we_b, re_b);
        end else if (exp_b.size() == 0) begin
          errors++; $display("FAIL b_unexpected_strobe: we=%b re=%b addr=%h, required none", we_b, re_b, addr_b);
        end else begin
          e = exp_b.pop_front();
          if (e.wr !== we_b || e.addr !== {4'h0, addr_b} || (e.wr && e.data !== wdata_b)) begin
            errors++;
            $display("FAIL b_strobe: we=%b addr=%h data=%h, required we=%b addr=%h data=%h",
                     we_b, addr_b, wdata_b, e.wr, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    s = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(~send_ack, s);
  endtask

  // Sends n bytes, byte i taken from bits [8i+7:8i]; returns the ACK of each.
  task automatic send_seq(input logic [63:0] bytes, input int n, output logic [7:0] acks);
    logic a;
    acks = '0;
    for (int i = 0; i < n; i++) begin
      write_byte(bytes[8*i +: 8], a);
      acks[i] = a;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(3);
    checks++;
    if ({oe_a, we_a, re_a, busy_a, addr_a, wdata_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: oe=%b we=%b re=%b busy=%b addr=%h wdata=%h, required all 0",
               oe_a, we_a, re_a, busy_a, addr_a, wdata_a);
    end
    checks++;
    if ({oe_b, we_b, re_b, busy_b, addr_b, wdata_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: oe=%b we=%b re=%b busy=%b addr=%h wdata=%h, required all 0",
               oe_b, we_b, re_b, busy_b, addr_b, wdata_b);
    end
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_write_pointer();
    logic [7:0] acks;
    bus_start();
    send_seq(64'h54, 1, acks);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL wp_busy: got %b, required 1", busy_a); end
    exp_a.push_back(mk_ev(1'b1, 8'h05, 32'h0010_0013));
    send_seq(64'h0010_0013_05, 5, acks);
    bus_stop();
    checks++;
    if (acks[4:0] !== 5'h1F) begin errors++; $display("FAIL wp_acks: got %b, required 11111", acks[4:0]); end
    checks++;
    if (addr_a !== 8'h06) begin errors++; $display("FAIL wp_ptr: got %h, required 06", addr_a); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL wp_busy_after_stop: got %b, required 0", busy_a); end
    checks++;
    if (exp_a.size() != 0) begin errors++; $display("FAIL wp_missing_we: pending %0d, required 0", exp_a.size()); end
  endtask

  task automatic test_wrap();
    logic [7:0] acks;
    exp_a.push_back(mk_ev(1'b1, 8'hFF, 32'h0403_0201));
    exp_a.push_back(mk_ev(1'b1, 8'h00, 32'h0807_0605));
    bus_start();
    send_seq(64'hFF54, 2, acks);
    checks++;
    if (acks[1:0] !== 2'b11) begin errors++; $display("FAIL wrap_hdr_acks: got %b, required 11", acks[1:0]); end
    send_seq(64'h0807_0605_0403_0201, 8, acks);
    bus_stop();
    checks++;
    if (acks !== 8'hFF) begin errors++; $display("FAIL wrap_data_acks: got %b, required 11111111", acks); end
    checks++;
    if (addr_a !== 8'h01) begin errors++; $display("FAIL wrap_ptr: got %h, required 01", addr_a); end
    checks++;
    if (exp_a.size() != 0) begin errors++; $display("FAIL wrap_missing_we: pending %0d, required 0", exp_a.size()); end
  endtask

  task automatic test_readback();
    logic [7:0] acks;
    logic [7:0] d, e;
    exp_a.push_back(mk_ev(1'b1, 8'h05, 32'hDEAD_BEEF));
    exp_a.push_back(mk_ev(1'b1, 8'h06, 32'h4433_2211));
    bus_start();
    send_seq(64'h4433_2211_DEAD_BEEF, 0, acks);
    send_seq(64'h0554, 2, acks);
    send_seq(64'h4433_2211_DEAD_BEEF, 8, acks);
    bus_stop();
    checks++;
    if (acks !== 8'hFF) begin errors++; $display("FAIL rb_fill_acks: got %b, required 11111111", acks); end

    for (int pass = 0; pass < 2; pass++) begin
      int nbytes;
      nbytes = (pass == 0) ? 4 : 8;
      bus_start();
      send_seq(64'h0554, 2, acks);
      bus_start();
      exp_a.push_back(mk_ev(1'b0, 8'h05, 32'h0));
      if (pass == 1) exp_a.push_back(mk_ev(1'b0, 8'h06, 32'h0));
      send_seq(64'h55, 1, acks);
      checks++;
      if (acks[0] !== 1'b1) begin errors++; $display("FAIL rb_addr_ack%0d: got %b, required 1", pass, acks[0]); end
      for (int i = 0; i < nbytes; i++) exp_rd.push_back(64'h4433_2211_DEAD_BEEF >> (8*i));
      for (int i = 0; i < nbytes; i++) begin
        read_byte(i != nbytes - 1, d);
        e = exp_rd.pop_front();
        checks++;
        if (d !== e) begin errors++; $display("FAIL rb_byte%0d_%0d: got %h, required %h", pass, i, d, e); end
      end
      bus_stop();
      checks++;
      if (addr_a !== ((pass == 0) ? 8'h05 : 8'h06)) begin
        errors++; $display("FAIL rb_ptr%0d: got %h, required %h", pass, addr_a, (pass == 0) ? 8'h05 : 8'h06);
      end
      checks++;
      if (exp_a.size() != 0) begin errors++; $display("FAIL rb_missing_re%0d: pending %0d, required 0", pass, exp_a.size()); end
    end
  endtask

  task automatic test_addr_mismatch();
    logic [7:0] acks;
    bus_start();
    send_seq(64'h0056, 2, acks);
    checks++;
    if (acks[1:0] !== 2'b00) begin errors++; $display("FAIL mm_acks: got %b, required 00", acks[1:0]); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL mm_busy: got %b, required 0", busy_a); end
    bus_stop();
    checks++;
    if (addr_a !== 8'h06) begin errors++; $display("FAIL mm_ptr: got %h, required 06", addr_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] acks;
    exp_a.push_back(mk_ev(1'b1, 8'h20, 32'h1357_9BDF));
    exp_a.push_back(mk_ev(1'b1, 8'h30, 32'h0246_8ACE));
    bus_start();
    send_seq(64'h1357_9BDF_2054, 6, acks);
    checks++;
    if (acks[5:0] !== 6'h3F) begin errors++; $display("FAIL b2b_acks1: got %b, required 111111", acks[5:0]); end
    bus_start();
    send_seq(64'h0246_8ACE_3054, 6, acks);
    bus_stop();
    checks++;
    if (acks[5:0] !== 6'h3F) begin errors++; $display("FAIL b2b_acks2: got %b, required 111111", acks[5:0]); end
    checks++;
    if (addr_a !== 8'h31) begin errors++; $display("FAIL b2b_ptr: got %h, required 31", addr_a); end
    checks++;
    if (exp_a.size() != 0) begin errors++; $display("FAIL b2b_missing_we: pending %0d, required 0", exp_a.size()); end
  endtask

  task automatic test_bad_pointer();
    logic [7:0] acks;
    bus_start();
    send_seq(64'h1122_3344_2078, 6, acks);
    bus_stop();
    checks++;
    if (acks[5:0] !== 6'b000001) begin errors++; $display("FAIL bp_0x20_acks: got %b, required 000001", acks[5:0]); end
    bus_start();
    send_seq(64'h0C78, 2, acks);
    bus_stop();
    checks++;
    if (acks[1:0] !== 2'b01) begin errors++; $display("FAIL bp_0x0c_acks: got %b, required 01", acks[1:0]); end
    checks++;
    if (addr_b !== 4'h0) begin errors++; $display("FAIL bp_ptr_kept: got %h, required 0", addr_b); end
    exp_b.push_back(mk_ev(1'b1, 8'h0B, 32'hA4A3_A2A1));
    exp_b.push_back(mk_ev(1'b1, 8'h00, 32'hB4B3_B2B1));
    bus_start();
    send_seq(64'h0B78, 2, acks);
    checks++;
    if (acks[1:0] !== 2'b11) begin errors++; $display("FAIL bp_0x0b_acks: got %b, required 11", acks[1:0]); end
    send_seq(64'hB4B3_B2B1_A4A3_A2A1, 8, acks);
    bus_stop();
    checks++;
    if (addr_b !== 4'h1) begin errors++; $display("FAIL bp_wrap_ptr: got %h, required 1", addr_b); end
    checks++;
    if (exp_b.size() != 0) begin errors++; $display("FAIL bp_missing_we: pending %0d, required 0", exp_b.size()); end
  endtask

  task automatic test_abort_reset();
    logic [7:0] acks;
    logic s;
    int waited;
    bus_start();
    send_seq(64'hBBAA_0754, 4, acks);
    bus_stop();
    checks++;
    if (addr_a !== 8'h07) begin errors++; $display("FAIL ab_stop_ptr: got %h, required 07", addr_a); end
    exp_a.push_back(mk_ev(1'b1, 8'h09, 32'h0403_0201));
    bus_start();
    send_seq(64'hCC_0954, 3, acks);
    bus_start();
    send_seq(64'h0403_0201_0954, 6, acks);
    bus_stop();
    checks++;
    if (addr_a !== 8'h0A) begin errors++; $display("FAIL ab_rstart_ptr: got %h, required 0a", addr_a); end
    checks++;
    if (exp_a.size() != 0) begin errors++; $display("FAIL ab_missing_we: pending %0d, required 0", exp_a.size()); end

    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(1'(8'h54 >> i), s);
    sda_m = 1'b1;
    waited = 0;
    while (oe_a !== 1'b1 && waited < 20) begin
      wait_clk(1);
      waited++;
    end
    checks++;
    if (oe_a !== 1'b1) begin errors++; $display("FAIL rst_pre_ack: oe got %b, required 1", oe_a); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({oe_a, busy_a, addr_a} !== 10'h000) begin
      errors++; $display("FAIL rst_mid: oe=%b busy=%b ptr=%h, required 0 0 00", oe_a, busy_a, addr_a);
    end
    wait_clk(2);
    rst = 1'b0;
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b1;
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(2*Q);
  endtask

  initial begin
    test_reset();
    test_write_pointer();
    test_wrap();
    test_readback();
    test_addr_mismatch();
    test_back_to_back();
    test_bad_pointer();
    test_abort_reset();
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++; $display("FAIL final_queues: a=%0d b=%0d pending, required 0", exp_a.size(), exp_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
